// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window-building blocks: controller
// state encoding, default counter width and the per-frame window count.
package conv_pkg;

  localparam int CNT_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Number of KxK windows produced per frame at the given stride (floor division).
  function automatic int win_count(input int img_w, input int img_h,
                                   input int ksize, input int stride);
    return ((img_h - ksize) / stride + 1) * ((img_w - ksize) / stride + 1);
  endfunction

endpackage

// File: rtl/stride_phase_cnt.sv
// Mod-STRIDE phase counter with an output-index counter that advances each
// time the phase wraps; phase 0 marks a position where a window lands.
module stride_phase_cnt #(
  parameter int STRIDE = 1,
  parameter int CNT_W  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             step_i,
  output logic             phase0_o,
  output logic [CNT_W-1:0] idx_o
);

  localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STRIDE - 1);

  logic [PH_W-1:0]  phase_q;
  logic [CNT_W-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      idx_q   <= '0;
    end else if (clr_i) begin
      phase_q <= '0;
      idx_q   <= '0;
    end else if (step_i) begin
      if (phase_q == PH_LAST) begin
        phase_q <= '0;
        idx_q   <= idx_q + 1'b1;
      end else begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end

  assign phase0_o = (phase_q == '0);
  assign idx_o    = idx_q;

endmodule

// File: rtl/line_window_ctrl.sv
// Line-buffer sequencer for a KxK convolution window: tracks raster position,
// drives the KSIZE-1 line FIFO enables and flags strided window positions.
module line_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 10,
  parameter int KSIZE      = 3,
  parameter int STRIDE     = 1,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             out_ready,
  output logic             lb_flush,
  output logic [KSIZE-2:0] lb_wr_en,
  output logic [KSIZE-2:0] lb_rd_en,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] K_FIRST  = CNT_W'(KSIZE - 1);

  state_e           state_q;
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic             win_valid_q, frame_done_q;
  logic [CNT_W-1:0] win_row_q, win_col_q;
  logic             acc, col_wrap, last_pix, win_hit;
  logic             row_ph0, col_ph0;
  logic [CNT_W-1:0] row_idx, col_idx;

  assign pix_ready = ((state_q == FILL) || (state_q == RUN)) && out_ready && !frame_start;
  assign acc       = pix_valid && pix_ready;
  assign col_wrap  = acc && (col_q == COL_LAST);
  assign last_pix  = col_wrap && (row_q == ROW_LAST);
  assign lb_flush  = frame_start;
  assign lb_wr_en  = {(KSIZE-1){acc}};

  // Line i only starts draining once a full row has been pushed into it.
  always_comb begin
    lb_rd_en = '0;
    for (int i = 0; i < KSIZE - 1; i++) begin
      lb_rd_en[i] = acc && (row_q > CNT_W'(i));
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (frame_start) begin
      row_d = '0;
      col_d = '0;
    end else if (acc) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  stride_phase_cnt #(.STRIDE(STRIDE), .CNT_W(CNT_W)) u_row_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (frame_start || last_pix),
    .step_i   (col_wrap && !last_pix && (row_q >= K_FIRST)),
    .phase0_o (row_ph0),
    .idx_o    (row_idx)
  );

  stride_phase_cnt #(.STRIDE(STRIDE), .CNT_W(CNT_W)) u_col_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (frame_start || col_wrap),
    .step_i   (acc && !col_wrap && (col_q >= K_FIRST)),
    .phase0_o (col_ph0),
    .idx_o    (col_idx)
  );

  assign win_hit = acc && (row_q >= K_FIRST) && (col_q >= K_FIRST) && row_ph0 && col_ph0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      win_valid_q  <= win_hit;
      frame_done_q <= 1'b0;
      if (win_hit) begin
        win_row_q <= row_idx;
        win_col_q <= col_idx;
      end
      if (frame_start) begin
        state_q <= FILL;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          FILL: if (row_d >= K_FIRST) state_q <= RUN;
          RUN: begin
            if (last_pix) begin
              state_q      <= DONE;
              frame_done_q <= 1'b1;
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: two instances (stride 1 and 2) share one input
// stream and are compared every cycle against a raster-position reference model.
module tb_line_window_ctrl;

  localparam int W = 10;
  localparam int H = 10;
  localparam int K = 3;

  logic clk = 1'b0;
  logic rst_n, frame_start, pix_valid, out_ready;

  logic [1:0] pr, fl, wv, bz, fd;
  logic [1:0] wr [2];
  logic [1:0] rd [2];
  logic [8:0] wrow [2];
  logic [8:0] wcol [2];

  int  n_cmp, n_err;
  int  n;
  bit  m_active, m_done;
  bit  e_wv [2];
  int  e_wr [2];
  int  e_wc [2];
  int  wcnt [2];
  bit  seen_done;

  always #5 clk = ~clk;

  line_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KSIZE(K), .STRIDE(1), .CNT_W(9)) u_s1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_ready(pr[0]), .out_ready(out_ready), .lb_flush(fl[0]), .lb_wr_en(wr[0]),
    .lb_rd_en(rd[0]), .win_valid(wv[0]), .win_row(wrow[0]), .win_col(wcol[0]),
    .busy(bz[0]), .frame_done(fd[0])
  );

  line_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KSIZE(K), .STRIDE(2), .CNT_W(9)) u_s2 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_ready(pr[1]), .out_ready(out_ready), .lb_flush(fl[1]), .lb_wr_en(wr[1]),
    .lb_rd_en(rd[1]), .win_valid(wv[1]), .win_row(wrow[1]), .win_col(wcol[1]),
    .busy(bz[1]), .frame_done(fd[1])
  );

  function automatic int strd(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_active = 0; m_done = 0; seen_done = 0;
    for (int d = 0; d < 2; d++) begin
      e_wv[d] = 0; e_wr[d] = 0; e_wc[d] = 0; wcnt[d] = 0;
    end
  endtask

  task automatic rst_check();
    for (int d = 0; d < 2; d++) begin
      chk("rst_pix_ready", 32'(pr[d]), 0);
      chk("rst_lb_flush", 32'(fl[d]), 0);
      chk("rst_lb_wr_en", 32'(wr[d]), 0);
      chk("rst_lb_rd_en", 32'(rd[d]), 0);
      chk("rst_win_valid", 32'(wv[d]), 0);
      chk("rst_win_row", 32'(wrow[d]), 0);
      chk("rst_win_col", 32'(wcol[d]), 0);
      chk("rst_busy", 32'(bz[d]), 0);
      chk("rst_frame_done", 32'(fd[d]), 0);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance, check registered outputs.
  task automatic cyc(input logic fs, input logic pv, input logic ordy);
    int r, c;
    logic e_rdy, a, e_fd;
    logic [1:0] e_rd;
    frame_start = fs; pix_valid = pv; out_ready = ordy;
    #1;
    r = n / W;
    c = n % W;
    e_rdy = m_active && ordy && !fs;
    a = pv && e_rdy;
    for (int i = 0; i < 2; i++) e_rd[i] = a && (r > i);
    for (int d = 0; d < 2; d++) begin
      chk("pix_ready", 32'(pr[d]), 32'(e_rdy));
      chk("lb_flush", 32'(fl[d]), 32'(fs));
      chk("lb_wr_en", 32'(wr[d]), 32'({a, a}));
      chk("lb_rd_en", 32'(rd[d]), 32'(e_rd));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (a && r >= K - 1 && c >= K - 1 && ((r - K + 1) % strd(d)) == 0 && ((c - K + 1) % strd(d)) == 0) begin
        e_wv[d] = 1;
        e_wr[d] = (r - K + 1) / strd(d);
        e_wc[d] = (c - K + 1) / strd(d);
      end else begin
        e_wv[d] = 0;
      end
    end
    e_fd = a && (n == W * H - 1);
    if (fs) begin
      m_active = 1; m_done = 0; n = 0; seen_done = 0;
      wcnt[0] = 0; wcnt[1] = 0;
    end else if (a) begin
      n++;
      if (n == W * H) begin
        m_active = 0;
        m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end
    for (int d = 0; d < 2; d++) begin
      chk("win_valid", 32'(wv[d]), 32'(e_wv[d]));
      chk("win_row", 32'(wrow[d]), e_wr[d]);
      chk("win_col", 32'(wcol[d]), e_wc[d]);
      chk("busy", 32'(bz[d]), 32'(m_active || m_done));
      chk("frame_done", 32'(fd[d]), 32'(e_fd));
      if (wv[d] === 1'b1) wcnt[d]++;
      if (fd[d] === 1'b1) seen_done = 1;
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input bit rnd, input int stop_at);
    for (int i = 0; i < 3000; i++) begin
      if (!m_active || (stop_at >= 0 && n >= stop_at)) break;
      if (rnd) cyc(1'b0, logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) != 0));
      else     cyc(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_win_s1"}, wcnt[0], 64);
    chk({tag, "_win_s2"}, wcnt[1], 16);
    chk({tag, "_done"}, 32'(seen_done), 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    rst_check();
    @(negedge clk);
    rst_n = 1'b1;

    // Pixels offered while idle are never accepted
    repeat (3) cyc(1'b0, 1'b1, 1'b1);

    // Continuous frame; the pixel coincident with frame_start is rejected
    cyc(1'b1, 1'b1, 1'b1);
    run_frame(1'b0, -1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    check_counts("cont");

    // Random pix_valid / out_ready
    cyc(1'b1, 1'b0, 1'b1);
    run_frame(1'b1, -1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    check_counts("stall");

    // Abort at pixel 37, then a full frame
    cyc(1'b1, 1'b1, 1'b1);
    run_frame(1'b0, 37);
    cyc(1'b1, 1'b1, 1'b1);
    chk("abort_no_done", 32'(seen_done), 0);
    run_frame(1'b1, -1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    check_counts("abort");

    // Asynchronous reset in the middle of a frame
    cyc(1'b1, 1'b1, 1'b1);
    run_frame(1'b0, 30);
    frame_start = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_check();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    run_frame(1'b0, -1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    check_counts("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
